tick_debouncer: RTL
===================

// Module: tick_debouncer
// PURPOSE
//   Debounces one raw asynchronous input (button/switch) into a clean level plus
//   one-cycle rise/fall pulses. Sits directly downstream of the free-running
//   counter: that counter's terminal-count strobe drives i_tick as the sample rate.
//   A change is accepted only after the synchronised input stays stable for
//   stable_ticks consecutive ticks.
// PARAMETERS
//   stable_ticks  4     ticks of unchanged input needed to accept a change (>=1)
//   sync_stages   2     synchroniser flop depth on i_raw (>=2)
//   init_level    1'b0  reset value of synchroniser, o_level and internal level
// PORTS
//   i_clk     in   1                         system clock, all logic on posedge
//   i_rst     in   1                         async reset, active-high
//   i_tick    in   1                         sample strobe, 1 clk wide, from counter
//   i_raw     in   1                         raw asynchronous input
//   o_level   out  1                         debounced level
//   o_rise    out  1                         1-clk pulse when o_level goes 0->1
//   o_fall    out  1                         1-clk pulse when o_level goes 1->0
//   o_busy    out  1                         high while a candidate change is qualifying
//   o_cnt     out  $clog2(stable_ticks+1)    ticks qualified so far (debug)
// BEHAVIOUR
//   Reset (async assert, sync release): sync chain=init_level, o_level=init_level,
//     o_rise=o_fall=o_busy=0, o_cnt=0, FSM=STABLE.
//   Synchroniser: i_raw through sync_stages flops -> s_in. No other logic sees i_raw.
//   FSM: two states, STABLE and QUALIFY.
//     STABLE: s_in==o_level -> stay. s_in!=o_level -> QUALIFY, o_cnt=0.
//       i_tick in this cycle is not counted.
//     QUALIFY: s_in==o_level (bounce) -> STABLE, o_cnt=0, no output change.
//       Bounce and i_tick in the same cycle: bounce wins.
//       s_in!=o_level & i_tick & o_cnt==stable_ticks-1 -> commit: o_level<=s_in,
//       pulse rise/fall, o_cnt=0, -> STABLE.
//       s_in!=o_level & i_tick otherwise -> o_cnt+1.
//       No tick -> hold.
//   o_busy = (state==QUALIFY), registered.
//   o_rise/o_fall are registered and assert in the same cycle o_level changes.
//     Both are low in all other cycles and never high together.
//   Latency raw edge -> o_level: sync_stages clks + 1 clk (enter QUALIFY)
//     + stable_ticks ticks. The commit lands on the edge that samples the final tick.
//   i_tick held high continuously: every clk counts as a tick. Legal.
//   o_cnt never exceeds stable_ticks-1. No wrap.
//   Reset asserted mid-QUALIFY: candidate discarded, all outputs reset immediately.
//   Elaboration error if stable_ticks<1 or sync_stages<2.
// TESTING
//   1 Reset with init_level=0, i_raw=1 held -> o_level=0, o_busy=0, all pulses 0.
//     After release, o_rise exactly once.
//   2 stable_ticks=4, tick every 8 clks, i_raw 0->1 clean -> o_busy rises 3 clks
//     after the edge; o_level=1 with o_rise 1-clk on the 4th counted tick.
//   3 Bounce: i_raw high for 2 ticks then low -> o_busy drops, o_cnt=0,
//     o_level stays 0, no pulses.
//   4 Bounce and i_tick in the same cycle with o_cnt=3 -> no commit,
//     return to STABLE.
//   5 stable_ticks=1, i_tick=1 constant, i_raw 1->0 -> o_level falls
//     sync_stages+2 clks after the edge; o_fall 1-clk.
//   6 Async i_rst pulse mid-QUALIFY (o_cnt=2) -> outputs reset without a clock.
//     Post-release, re-qualification restarts from 0.

Source files
------------

// File: rtl/tick_debouncer_if.sv
// Bundles the sample strobe, raw input and debounced outputs of tick_debouncer.
// The counter width follows stable_ticks, so instantiate with the same value as the debouncer.
interface tick_debouncer_if #(
    parameter int stable_ticks = 4
) ();
    localparam int CW = $clog2(stable_ticks + 1);

    logic          i_tick;
    logic          i_raw;
    logic          o_level;
    logic          o_rise;
    logic          o_fall;
    logic          o_busy;
    logic [CW-1:0] o_cnt;

    // Driver side: produces tick/raw and observes the debounced outputs.
    modport master (
        output i_tick, i_raw,
        input  o_level, o_rise, o_fall, o_busy, o_cnt
    );

    // Debouncer side.
    modport slave (
        input  i_tick, i_raw,
        output o_level, o_rise, o_fall, o_busy, o_cnt
    );
endinterface

// File: rtl/tick_debouncer.sv
// Tick-sampled debouncer. The raw input passes through a synchroniser chain.
// A level change is accepted only after the synchronised value differs from
// the current level for stable_ticks consecutive sample ticks.
module tick_debouncer #(
    parameter int   stable_ticks = 4,
    parameter int   sync_stages  = 2,
    parameter logic init_level   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    tick_debouncer_if.slave  bus
);
    localparam int CW = $clog2(stable_ticks + 1);
    localparam logic [CW-1:0] LAST = CW'(stable_ticks - 1);

    if (stable_ticks < 1) begin : g_bad_ticks
        $error("tick_debouncer: stable_ticks must be >= 1");
    end
    if (sync_stages < 2) begin : g_bad_sync
        $error("tick_debouncer: sync_stages must be >= 2");
    end

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    logic [sync_stages-1:0] sync_q;
    logic                   s_in;
    state_t                 state_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;
    logic [CW-1:0]          cnt_q;

    // Synchroniser chain; the only consumer of the raw input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= {sync_stages{init_level}};
        end else begin
            sync_q <= {sync_q[sync_stages-2:0], bus.i_raw};
        end
    end

    assign s_in = sync_q[sync_stages-1];

    // Qualification FSM with registered level, edge pulses, busy and tick count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= STABLE;
            level_q <= init_level;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            unique case (state_q)
                STABLE: begin
                    // Entering QUALIFY never counts a tick in the same cycle.
                    if (s_in != level_q) begin
                        state_q <= QUALIFY;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                QUALIFY: begin
                    // Bounce takes priority over a coincident tick.
                    if (s_in == level_q) begin
                        state_q <= STABLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (bus.i_tick) begin
                        if (cnt_q == LAST) begin
                            level_q <= s_in;
                            rise_q  <= s_in;
                            fall_q  <= ~s_in;
                            state_q <= STABLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= STABLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.o_level = level_q;
    assign bus.o_rise  = rise_q;
    assign bus.o_fall  = fall_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_cnt   = cnt_q;
endmodule
